imem_loader: RTL

//  Boot-time writer for the instruction memory. Consumes a byte stream (valid/ready), packs bytes

---
 rtl/imem_loader_pkg.sv | 17 +
 rtl/imem_loader_word_packer.sv | 34 +++
 rtl/imem_loader.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package imem_loader_pkg;

    localparam int BYTES_PER_WORD = 4;
    localparam int LEN_W          = 16;

    typedef enum logic [2:0] {
        IDLE,
        LEN_LO,
        LEN_HI,
        DATA,
        WRITE,
        CSUM,
        DONE
    } state_t;

endpackage

// File: rtl/imem_loader_word_packer.sv
// Packs a little-endian byte stream into 32-bit words. The first byte of a
// word ends up in bits [7:0]. word_valid_o pulses alongside the 4th byte.
module imem_loader_word_packer
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear_i,
    input  logic        byte_valid_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] word_o,
    output logic        word_valid_o
);

    logic [1:0]  idx_q;
    logic [31:0] word_q;

    // Shift each new byte in from the top so byte 0 lands at the bottom after 4 bytes.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q  <= '0;
            word_q <= '0;
        end else if (clear_i) begin
            idx_q  <= '0;
        end else if (byte_valid_i) begin
            idx_q  <= idx_q + 2'd1;
            word_q <= {byte_i, word_q[31:8]};
        end
    end

    assign word_o       = word_q;
    assign word_valid_o = byte_valid_i && (idx_q == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/imem_loader.sv
// Boot-time instruction memory loader: LEN_LO, LEN_HI, then 4*N data bytes,
// one imem write per packed word. Holds the core until a clean load finishes.
// Optional trailing XOR checksum byte: define IMEM_LOADER_CHECKSUM_EN.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_wr_en,
    output logic [ADDR_W-1:0] mem_wr_addr,
    output logic [31:0]       mem_wr_data,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              cpu_hold,
    output logic [ADDR_W:0]   words_loaded
);

    localparam logic [LEN_W:0] DEPTH = (LEN_W+1)'(2**ADDR_W);

`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam state_t END_ST = CSUM;
    logic [7:0] csum_q, csum_d;
`else
    localparam state_t END_ST = DONE;
`endif

    state_t             state_q, state_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [ADDR_W:0]    words_q, words_d;
    logic               err_q, err_d;

    logic               accept;
    logic               start_ok;
    logic [LEN_W-1:0]   len_full;
    logic [31:0]        word;
    logic               word_valid;

    assign start_ok = start && (state_q == IDLE || state_q == DONE);
    assign accept   = in_valid && in_ready;
    assign len_full = {in_data, len_q[7:0]};

    imem_loader_word_packer u_packer (
        .clk          (clk),
        .rst          (rst),
        .clear_i      (start_ok),
        .byte_valid_i (accept && state_q == DATA),
        .byte_i       (in_data),
        .word_o       (word),
        .word_valid_o (word_valid)
    );

    // Next-state and load bookkeeping.
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        addr_d  = addr_q;
        words_d = words_q;
        err_d   = err_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum_d  = accept ? (csum_q ^ in_data) : csum_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = LEN_LO;
                    addr_d  = '0;
                    words_d = '0;
                    err_d   = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    csum_d  = '0;
`endif
                end
            end
            LEN_LO: begin
                if (accept) begin
                    len_d   = {8'h00, in_data};
                    state_d = LEN_HI;
                end
            end
            LEN_HI: begin
                if (accept) begin
                    len_d = len_full;
                    if ({1'b0, len_full} > DEPTH) begin
                        // Oversize program never reaches the checksum stage.
                        err_d   = 1'b1;
                        state_d = DONE;
                    end else if (len_full == '0) begin
                        state_d = END_ST;
                    end else begin
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (word_valid) state_d = WRITE;
            end
            WRITE: begin
                addr_d  = addr_q + 1'b1;
                words_d = words_q + 1'b1;
                state_d = (LEN_W'(words_q) + 1'b1 < len_q) ? DATA : END_ST;
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            CSUM: begin
                if (accept) begin
                    if (in_data != csum_q) err_d = 1'b1;
                    state_d = DONE;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset aborts a load without touching imem.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            len_q   <= '0;
            addr_q  <= '0;
            words_q <= '0;
            err_q   <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            addr_q  <= addr_d;
            words_q <= words_d;
            err_q   <= err_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q  <= csum_d;
`endif
        end
    end

    assign in_ready     = (state_q == LEN_LO) || (state_q == LEN_HI) ||
                          (state_q == DATA)   || (state_q == CSUM);
    assign mem_wr_en    = (state_q == WRITE);
    assign mem_wr_addr  = addr_q;
    assign mem_wr_data  = word;
    assign busy         = (state_q != IDLE) && (state_q != DONE);
    assign done         = (state_q == DONE);
    assign err          = err_q;
    assign cpu_hold     = !((state_q == DONE) && !err_q);
    assign words_loaded = words_q;

endmodule
